// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and flag formation for the multi-cycle ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_SLT = 4'd4;
   localparam logic [3:0] OP_NOR = 4'd5;
   localparam logic [3:0] OP_SLL = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   typedef struct packed {
      logic zero;
      logic carry;
      logic ovf;
   } flags_t;

   // Undefined opcodes report all flags clear even though their result is 0.
   function automatic flags_t calc_flags(input logic known_op, input logic arith,
                                         input logic res_zero, input logic c,
                                         input logic v);
      flags_t f;
      f.zero  = known_op & res_zero;
      f.carry = arith & c;
      f.ovf   = arith & v;
      return f;
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit logic/add/sub/slt unit with raw carry-out and signed overflow.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res,
   output logic             carry,
   output logic             ovf
);

   logic             sub;
   logic [WIDTH-1:0] bx;
   logic [WIDTH:0]   sum;

   assign sub   = (op == OP_SUB) || (op == OP_SLT);
   assign bx    = sub ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
   assign carry = sum[WIDTH];
   assign ovf   = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      res = '0;
      case (op)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_ADD:  res = sum[WIDTH-1:0];
         OP_SUB:  res = sum[WIDTH-1:0];
         // Sign of a-b corrected by overflow gives the true signed ordering.
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
         OP_NOR:  res = ~(a | b);
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops via alu_core, iterative shift and shift-add multiply.
module alu_mc
   import alu_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             ovf
);

   state_t           state, state_nxt;
   logic [SHW:0]     cnt;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] work, mplier, acc;
   flags_t           flags, flags_nxt;

   logic [WIDTH-1:0] core_res;
   logic             core_c, core_v;

   logic             accept, is_shift, is_mul, go_exec, last_step, load_result;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] single_res, work_step, acc_step, final_res, result_nxt;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op    (op),
      .a     (a),
      .b     (b),
      .res   (core_res),
      .carry (core_c),
      .ovf   (core_v)
   );

   assign ready     = (state == IDLE);
   assign done      = (state == DONE);
   assign accept    = start && ready;
   assign shamt     = b[SHW-1:0];
   assign is_shift  = (op == OP_SLL) || (op == OP_SRL);
   assign is_mul    = (op == OP_MUL);
   assign go_exec   = is_mul || (is_shift && (shamt != '0));
   assign last_step = (state == EXEC) && (cnt == (SHW+1)'(1));

   // The work register is the shifter in SLL/SRL and the multiplicand in MUL.
   assign single_res = is_shift ? a : core_res;
   assign work_step  = (op_q == OP_SRL) ? (work >> 1) : (work << 1);
   assign acc_step   = acc + (mplier[0] ? work : '0);
   assign final_res  = (op_q == OP_MUL) ? acc_step : work_step;

   always_comb begin
      state_nxt   = state;
      load_result = 1'b0;
      result_nxt  = single_res;
      flags_nxt   = calc_flags(op <= OP_MUL, (op == OP_ADD) || (op == OP_SUB),
                               single_res == '0, core_c, core_v);
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt   = go_exec ? EXEC : DONE;
               load_result = !go_exec;
            end
         end
         EXEC: begin
            result_nxt = final_res;
            flags_nxt  = calc_flags(1'b1, 1'b0, final_res == '0, 1'b0, 1'b0);
            if (last_step) begin
               state_nxt   = DONE;
               load_result = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         op_q   <= '0;
         work   <= '0;
         mplier <= '0;
         acc    <= '0;
         result <= '0;
         flags  <= '0;
      end else begin
         if (accept && go_exec) begin
            op_q   <= op;
            work   <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= is_mul ? (SHW+1)'(WIDTH) : {1'b0, shamt};
         end else if (state == EXEC) begin
            work   <= work_step;
            mplier <= mplier >> 1;
            acc    <= acc_step;
            cnt    <= cnt - 1'b1;
         end
         if (load_result) begin
            result <= result_nxt;
            flags  <= flags_nxt;
         end
      end
   end

   assign zero  = flags.zero;
   assign carry = flags.carry;
   assign ovf   = flags.ovf;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=8: expected {result,zero,carry,ovf} queued at issue, checked at done.
module tb_alu_mc;

   localparam logic [3:0] T_AND = 4'd0, T_OR = 4'd1, T_ADD = 4'd2, T_SUB = 4'd3,
                          T_SLT = 4'd4, T_NOR = 4'd5, T_SLL = 4'd6, T_SRL = 4'd7,
                          T_MUL = 4'd8;

   logic       clk, rst, start;
   logic [3:0] op;
   logic [7:0] a, b;
   logic       ready, done, zero, carry, ovf;
   logic [7:0] result;

   logic [10:0] exp_q[$];
   int          n_cmp, n_err;

   alu_mc #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .ready  (ready),
      .done   (done),
      .result (result),
      .zero   (zero),
      .carry  (carry),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [10:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
      logic [7:0] r;
      logic       z, c, v;
      int         sx, sy, s;
      sx = int'($signed(x));
      sy = int'($signed(y));
      r = 8'h00; c = 1'b0; v = 1'b0; z = 1'b0;
      case (o)
         T_AND: r = x & y;
         T_OR:  r = x | y;
         T_ADD: begin
            s = sx + sy; r = 8'(int'(x) + int'(y));
            c = (int'(x) + int'(y)) > 255; v = (s > 127) || (s < -128);
         end
         T_SUB: begin
            s = sx - sy; r = 8'(int'(x) - int'(y));
            c = (x >= y); v = (s > 127) || (s < -128);
         end
         T_SLT: r = (sx < sy) ? 8'h01 : 8'h00;
         T_NOR: r = ~(x | y);
         T_SLL: r = x << y[2:0];
         T_SRL: r = x >> y[2:0];
         T_MUL: r = 8'((int'(x) * int'(y)) % 256);
         default: r = 8'h00;
      endcase
      if (o <= T_MUL) z = (r == 8'h00);
      return {r, z, c, v};
   endfunction

   function automatic int model_lat(input logic [3:0] o, input logic [7:0] y);
      if (o == T_MUL) return 9;
      if ((o == T_SLL || o == T_SRL) && y[2:0] != 3'd0) return int'(y[2:0]) + 1;
      return 1;
   endfunction

   // Waits for ready, presents the request across one edge, then scrambles the inputs.
   task automatic drive_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input bit track);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         n_cmp++; n_err++;
         $display("FAIL ready_timeout: ready=%b required 1", ready);
      end
      start = 1'b1; op = o; a = x; b = y;
      if (track) exp_q.push_back(model(o, x, y));
      @(posedge clk);
      #1;
      start = 1'b0;
      op = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = 8'($urandom);
   endtask

   task automatic collect(output logic [10:0] got, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 40);
      got = {result, zero, carry, ovf};
   endtask

   task automatic run_check(input string name, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
      logic [10:0] got, exp;
      int lat, exp_lat;
      exp_lat = model_lat(o, y);
      drive_op(o, x, y, 1'b1);
      collect(got, lat);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got {res,z,c,v}=%h_%b required %h_%b", name, got[10:3], got[2:0], exp[10:3], exp[2:0]);
      end
      n_cmp++;
      if (lat !== exp_lat) begin
         n_err++;
         $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({ready, done, result, zero, carry, ovf} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
         n_err++;
         $display("FAIL reset_hold: got rdy=%b done=%b res=%h zco=%b%b%b required 1 0 00 000",
                  ready, done, result, zero, carry, ovf);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({ready, done, result} !== {1'b1, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL reset_release: got rdy=%b done=%b res=%h required 1 0 00", ready, done, result);
      end
   endtask

   task automatic test_arith;
      run_check("add_7f_01", T_ADD, 8'h7F, 8'h01);
      run_check("sub_05_05", T_SUB, 8'h05, 8'h05);
      run_check("sub_00_01", T_SUB, 8'h00, 8'h01);
      run_check("add_ff_01", T_ADD, 8'hFF, 8'h01);
      run_check("and_f0_3c", T_AND, 8'hF0, 8'h3C);
      run_check("or_f0_0f",  T_OR,  8'hF0, 8'h0F);
      run_check("nor_f0_0f", T_NOR, 8'hF0, 8'h0F);
      run_check("undef_9",   4'd9,  8'h00, 8'h00);
   endtask

   task automatic test_slt;
      run_check("slt_ff_01", T_SLT, 8'hFF, 8'h01);
      run_check("slt_01_ff", T_SLT, 8'h01, 8'hFF);
      run_check("slt_80_7f", T_SLT, 8'h80, 8'h7F);
   endtask

   task automatic test_shift;
      run_check("sll_81_3", T_SLL, 8'h81, 8'h03);
      run_check("srl_81_0", T_SRL, 8'h81, 8'h00);
      run_check("srl_81_7", T_SRL, 8'h81, 8'h07);
      run_check("sll_01_f", T_SLL, 8'h01, 8'h0F);
   endtask

   task automatic test_mul;
      logic [10:0] got, exp;
      int lat, quiet;
      run_check("mul_0d_0b", T_MUL, 8'h0D, 8'h0B);
      drive_op(T_MUL, 8'h0D, 8'h0B, 1'b1);
      fork
         begin
            @(negedge clk);
            @(negedge clk);
            start = 1'b1; op = T_ADD; a = 8'h11; b = 8'h22;
            @(negedge clk);
            start = 1'b0;
         end
         collect(got, lat);
      join
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp || lat !== 9) begin
         n_err++;
         $display("FAIL mul_ignore_start: got %h lat %0d required %h lat 9", got, lat, exp);
      end
      quiet = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) quiet++;
      end
      n_cmp++;
      if (quiet !== 0) begin
         n_err++;
         $display("FAIL mul_no_extra_done: got %0d extra done cycles required 0", quiet);
      end
      run_check("mul_10_10", T_MUL, 8'h10, 8'h10);
   endtask

   task automatic test_reset_mid_mul;
      run_check("pre_reset_add", T_ADD, 8'h7F, 8'h01);
      drive_op(T_MUL, 8'hFF, 8'hFF, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({ready, done, result, zero, carry, ovf} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
         n_err++;
         $display("FAIL reset_mid_mul: got rdy=%b done=%b res=%h zco=%b%b%b required 1 0 00 000",
                  ready, done, result, zero, carry, ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      run_check("post_reset_add", T_ADD, 8'h12, 8'h34);
   endtask

   task automatic test_back_to_back;
      logic [10:0] got, exp;
      int lat;
      time t0, t1;
      drive_op(T_ADD, 8'h01, 8'h02, 1'b1);
      collect(got, lat);
      t0 = $time;
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL b2b_first: got %h required %h", got, exp);
      end
      drive_op(T_SUB, 8'h10, 8'h20, 1'b1);
      collect(got, lat);
      t1 = $time;
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp || (t1 - t0) !== 20) begin
         n_err++;
         $display("FAIL b2b_second: got %h spacing %0t required %h spacing 20", got, t1 - t0, exp);
      end
   endtask

   task automatic test_random;
      logic [3:0] o;
      logic [7:0] x, y;
      for (int i = 0; i < 24; i++) begin
         o = 4'($urandom_range(0, 15));
         x = 8'($urandom);
         y = 8'($urandom);
         run_check($sformatf("rand_%0d_op%0d", i, o), o, x, y);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_arith();
      test_slt();
      test_shift();
      test_mul();
      test_reset_mid_mul();
      test_back_to_back();
      test_random();
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_err++;
         $display("FAIL queue_drain: got %0d left required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised ALU for the datapath execute stage. It generalises the 1-bit slice ALU to a full WIDTH-bit unit:
- Logic, add/sub and set-less-than operations complete in one cycle.
- Shifts and multiply are iterative.
- Status flags are registered.
- A start/ready/done handshake lets control stall while an iterative operation runs.

## Interface
Parameters:
- WIDTH, 8, operand/result width (≥4, power of two)
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted on an edge where start=1 and ready=1
- op  in  4  opcode, sampled on accept
- a  in  WIDTH  operand A, sampled on accept
- b  in  WIDTH  operand B, sampled on accept; b[SHW-1:0] is the shift amount
- ready  out  1  unit idle, can accept
- done  out  1  one-cycle pulse: result/flags valid from this cycle
- result  out  WIDTH  registered result, held until the next done
- zero  out  1  result==0
- carry  out  1  ADD/SUB carry-out (SUB: no-borrow), else 0
- ovf  out  1  ADD/SUB signed overflow, else 0

## Operation
- Opcodes:
  - 0 AND
  - 1 OR
  - 2 ADD
  - 3 SUB (a + ~b + 1)
  - 4 SLT (signed a<b → 1, else 0)
  - 5 NOR
  - 6 SLL (a << shamt)
  - 7 SRL (logical)
  - 8 MUL (low WIDTH bits of unsigned a*b)
  - 9–15 undefined: result 0, flags 0, single-cycle
- FSM states IDLE, EXEC, DONE; ready = (state==IDLE).
- Transitions on accept:
  - Single-cycle op, or SLL/SRL with shamt=0: IDLE→DONE, with result/flags written on the accept edge.
  - SLL/SRL with shamt=n>0: IDLE→EXEC. Load the working register with a and the counter with n. Each EXEC edge shifts by 1 and decrements; counter reaching 0 → DONE.
  - MUL: IDLE→EXEC. Load the accumulator with 0, the multiplicand with a, the multiplier with b, and the counter with WIDTH. Each EXEC edge conditionally adds the multiplicand (multiplier LSB), shifts the multiplicand left, shifts the multiplier right and decrements the counter. Counter 0 → DONE.
- DONE→IDLE unconditionally after one cycle; done = (state==DONE).
- result/zero/carry/ovf update only on the edge entering DONE and hold otherwise. Iterative intermediates are never visible on result.
- start while ready=0 is ignored; no queueing. op/a/b changes after accept have no effect.
- Arithmetic is WIDTH+1-bit internally for carry; ovf = (a_msb==b'_msb) && (sum_msb!=a_msb), where b' = ~b for SUB.
- SLT uses the sign of the subtraction XOR ovf.
- Reset (any time, including mid-EXEC): state IDLE, result 0, zero 0, carry 0, ovf 0, done 0, counter 0. Any in-flight operation is discarded; ready=1 while rst=1 and after release.

## Timing
- Accept at edge k:
  - Single-cycle ops: done high in cycle k+1.
  - SLL/SRL by n>0: done in cycle k+n+1.
  - MUL: done in cycle k+WIDTH+1.
- The earliest next accept is the edge ending the done cycle. Back-to-back single-cycle throughput is therefore one op per 2 cycles.
- Outputs are driven from registers only, except ready, which is decoded from the state register. There is no combinational path from inputs to outputs.

## Structure
- Package alu_pkg:
  - opcode localparams OP_AND…OP_MUL
  - state enum IDLE/EXEC/DONE
  - the flag-computation function
- Sub-module alu_core: a purely combinational WIDTH-parametrised unit computing AND/OR/ADD/SUB/SLT/NOR plus carry/ovf. It is the width-generalised slice chain. alu_mc instantiates it and wraps it with the FSM, iterative shifter/multiplier and output registers.

## Test plan
All scenarios use WIDTH=8.
- ADD a=0x7F b=0x01 → result 0x80, ovf 1, carry 0, zero 0; done exactly 1 cycle after accept.
- SUB a=0x05 b=0x05 → 0x00, zero 1, carry 1, ovf 0. SUB a=0x00 b=0x01 → 0xFF, carry 0.
- SLT a=0xFF b=0x01 → 0x01. SLT a=0x01 b=0xFF → 0x00. SLT a=0x80 b=0x7F → 0x01 (overflow path).
- SLL a=0x81 b=3 → 0x08, done 4 cycles after accept. SRL a=0x81 b=0 → 0x81, done after 1 cycle. Both have carry/ovf 0.
- MUL a=0x0D b=0x0B → 0x8F, done 9 cycles after accept. A start pulse with different operands during EXEC is ignored and the result is unchanged. MUL 0x10*0x10 → 0x00, zero 1.
- Assert rst during cycle 4 of a MUL → result/flags 0, done 0, ready 1 immediately. A new ADD accepted right after release completes normally.
